// File: rtl/stage_three_wb.sv
// Memory/write-back stage: an IDLE/WAIT FSM runs the data-memory req/ack access and picks ALU or load data for write-back.
// Optional feature macro: STAGE_THREE_TIMEOUT_EN (bounded WAIT with a sticky mem_fault).
module stage_three_wb #(
   parameter int DATA_W         = 16,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  halt_sys,
   input  logic [2*DATA_W-1:0]   in_alu_result,
   input  logic [DATA_W-1:0]     in_R1_data,
   input  logic [1:0]            in_memc,
   input  logic                  in_reg_wr,
   input  logic                  in_R0_en,
   input  logic [7:0]            in_instr,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [DATA_W-1:0]     dmem_addr,
   output logic [DATA_W-1:0]     dmem_wdata,
   input  logic [DATA_W-1:0]     dmem_rdata,
   input  logic                  dmem_ack,
   output logic                  mem_busy,
   output logic [2*DATA_W-1:0]   s3_data,
   output logic                  s3_reg_wr,
   output logic                  s3_R0_en,
   output logic [7:0]            s3_instruction,
   output logic                  mem_fault
);

   typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

   state_t                r_state, w_state_nxt;
   logic                  w_capture, w_is_mem, w_ack_done, w_timeout, w_expire;
   logic                  r_dmem_req, r_dmem_we;
   logic [DATA_W-1:0]     r_dmem_addr, r_dmem_wdata;
   logic [2*DATA_W-1:0]   r_s3_data;
   logic                  r_s3_reg_wr, r_s3_R0_en;
   logic [7:0]            r_s3_instr;
   logic                  r_hold_reg_wr;
   logic [7:0]            r_hold_instr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_is_mem    = 1'b0;
      w_ack_done  = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!halt_sys) begin
               w_capture = 1'b1;
               w_is_mem  = (in_memc == 2'b01) || (in_memc == 2'b10);
               if (w_is_mem) w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // An ack arriving on the expiry cycle still completes the access normally.
            if (dmem_ack) begin
               w_ack_done  = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (w_expire) begin
               w_timeout   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dmem_req    <= 1'b0;
         r_dmem_we     <= 1'b0;
         r_dmem_addr   <= '0;
         r_dmem_wdata  <= '0;
         r_s3_data     <= '0;
         r_s3_reg_wr   <= 1'b0;
         r_s3_R0_en    <= 1'b0;
         r_s3_instr    <= '0;
         r_hold_reg_wr <= 1'b0;
         r_hold_instr  <= '0;
      end else begin
         r_s3_reg_wr <= 1'b0;
         if (w_capture && !w_is_mem) begin
            r_s3_data   <= in_alu_result;
            r_s3_reg_wr <= in_reg_wr;
            r_s3_R0_en  <= in_R0_en;
            r_s3_instr  <= in_instr;
         end else if (w_capture) begin
            r_dmem_req    <= 1'b1;
            r_dmem_we     <= in_memc[1];
            r_dmem_addr   <= in_alu_result[DATA_W-1:0];
            r_dmem_wdata  <= in_R1_data;
            r_hold_reg_wr <= in_reg_wr;
            r_hold_instr  <= in_instr;
         end else if (w_ack_done) begin
            r_dmem_req <= 1'b0;
            r_s3_instr <= r_hold_instr;
            if (!r_dmem_we) begin
               r_s3_data   <= {{DATA_W{1'b0}}, dmem_rdata};
               r_s3_reg_wr <= r_hold_reg_wr;
               r_s3_R0_en  <= 1'b0;
            end
         end else if (w_timeout) begin
            r_dmem_req <= 1'b0;
         end
      end
   end

`ifdef STAGE_THREE_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_tcnt;
   logic             r_mem_fault;

   // r_tcnt counts completed ack-less WAIT cycles; the TIMEOUT_CYCLES-th one aborts the access.
   assign w_expire = (r_tcnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tcnt      <= '0;
         r_mem_fault <= 1'b0;
      end else begin
         if (w_capture && w_is_mem)              r_tcnt <= '0;
         else if (r_state == ST_WAIT && !dmem_ack) r_tcnt <= r_tcnt + 1'b1;
         if (w_timeout) r_mem_fault <= 1'b1;
      end
   end

   assign mem_fault = r_mem_fault;
`else
   assign w_expire  = 1'b0;
   assign mem_fault = 1'b0;
`endif

   assign mem_busy       = (r_state == ST_WAIT);
   assign dmem_req       = r_dmem_req;
   assign dmem_we        = r_dmem_we;
   assign dmem_addr      = r_dmem_addr;
   assign dmem_wdata     = r_dmem_wdata;
   assign s3_data        = r_s3_data;
   assign s3_reg_wr      = r_s3_reg_wr;
   assign s3_R0_en       = r_s3_R0_en;
   assign s3_instruction = r_s3_instr;

endmodule

// File: tb/tb_stage_three_wb.sv
// Randomized bench for stage_three_wb: a transaction-level model predicts each write-back and memory request.
module tb_stage_three_wb;
   localparam int DATA_W         = 16;
   localparam int TIMEOUT_CYCLES = 15;

   logic                clk = 1'b0;
   logic                rst;
   logic                halt_sys;
   logic [2*DATA_W-1:0] in_alu_result;
   logic [DATA_W-1:0]   in_R1_data;
   logic [1:0]          in_memc;
   logic                in_reg_wr, in_R0_en;
   logic [7:0]          in_instr;
   logic                dmem_req, dmem_we;
   logic [DATA_W-1:0]   dmem_addr, dmem_wdata, dmem_rdata;
   logic                dmem_ack;
   logic                mem_busy;
   logic [2*DATA_W-1:0] s3_data;
   logic                s3_reg_wr, s3_R0_en;
   logic [7:0]          s3_instruction;
   logic                mem_fault;

   stage_three_wb #(.DATA_W(DATA_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
      .clk(clk), .rst(rst), .halt_sys(halt_sys),
      .in_alu_result(in_alu_result), .in_R1_data(in_R1_data), .in_memc(in_memc),
      .in_reg_wr(in_reg_wr), .in_R0_en(in_R0_en), .in_instr(in_instr),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .mem_busy(mem_busy),
      .s3_data(s3_data), .s3_reg_wr(s3_reg_wr), .s3_R0_en(s3_R0_en),
      .s3_instruction(s3_instruction), .mem_fault(mem_fault)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Model of the last architecturally visible write-back.
   logic [31:0] m_data  = '0;
   logic        m_dk    = 1'b1;
   logic [7:0]  m_instr = '0;
   logic        m_fault = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_junk();
      in_memc       = 2'($urandom);
      in_alu_result = $urandom;
      in_R1_data    = 16'($urandom);
      in_reg_wr     = 1'($urandom);
      in_R0_en      = 1'($urandom);
      in_instr      = 8'($urandom);
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_req"},   32'(dmem_req), 0);
      check_val({tag, "_busy"},  32'(mem_busy), 0);
      check_val({tag, "_we"},    32'(dmem_we), 0);
      check_val({tag, "_addr"},  32'(dmem_addr), 0);
      check_val({tag, "_wdata"}, 32'(dmem_wdata), 0);
      check_val({tag, "_data"},  s3_data, 0);
      check_val({tag, "_wr"},    32'(s3_reg_wr), 0);
      check_val({tag, "_r0"},    32'(s3_R0_en), 0);
      check_val({tag, "_instr"}, 32'(s3_instruction), 0);
      check_val({tag, "_fault"}, 32'(mem_fault), 0);
   endtask

   task automatic run_txn(input logic [1:0] memc, input logic [31:0] alu, input logic [15:0] r1,
                          input logic rw, input logic r0, input logic [7:0] ins, input int halt_pre,
                          input int ack_wait, input logic [15:0] rdata, input logic halt_wait);
      logic is_mem;
      logic exp_wr;
      is_mem = (memc == 2'b01) || (memc == 2'b10);
      for (int i = 0; i < halt_pre; i++) begin
         halt_sys = 1'b1;
         dmem_ack = 1'($urandom);
         drive_junk();
         tick();
         check_val("halt_wr",    32'(s3_reg_wr), 0);
         check_val("halt_instr", 32'(s3_instruction), 32'(m_instr));
         check_val("halt_busy",  32'(mem_busy), 0);
         check_val("halt_req",   32'(dmem_req), 0);
         if (m_dk) check_val("halt_data", s3_data, m_data);
      end
      halt_sys = 1'b0; dmem_ack = 1'b0;
      in_memc = memc; in_alu_result = alu; in_R1_data = r1;
      in_reg_wr = rw; in_R0_en = r0; in_instr = ins;
      tick();
      if (!is_mem) begin
         m_data = alu; m_dk = 1'b1; m_instr = ins;
         check_val("alu_data",  s3_data, m_data);
         check_val("alu_wr",    32'(s3_reg_wr), 32'(rw));
         check_val("alu_r0",    32'(s3_R0_en), 32'(r0));
         check_val("alu_instr", 32'(s3_instruction), 32'(ins));
         check_val("alu_busy",  32'(mem_busy), 0);
         check_val("alu_req",   32'(dmem_req), 0);
      end else begin
         check_val("mem_req",  32'(dmem_req), 1);
         check_val("mem_we",   32'(dmem_we), 32'(memc[1]));
         check_val("mem_addr", 32'(dmem_addr), 32'(alu[15:0]));
         check_val("mem_wdat", 32'(dmem_wdata), 32'(r1));
         check_val("mem_busy", 32'(mem_busy), 1);
         check_val("mem_bubl", 32'(s3_reg_wr), 0);
         for (int w = 0; w < ack_wait; w++) begin
            halt_sys = halt_wait; dmem_ack = 1'b0; drive_junk();
            tick();
            check_val("wait_busy", 32'(mem_busy), 1);
            check_val("wait_req",  32'(dmem_req), 1);
            check_val("wait_addr", 32'(dmem_addr), 32'(alu[15:0]));
            check_val("wait_wdat", 32'(dmem_wdata), 32'(r1));
            check_val("wait_wr",   32'(s3_reg_wr), 0);
         end
         halt_sys = halt_wait; drive_junk();
         dmem_ack = 1'b1; dmem_rdata = rdata;
         tick();
         dmem_ack = 1'b0;
         m_instr = ins;
         if (memc == 2'b01) begin
            m_data = {16'h0000, rdata}; m_dk = 1'b1; exp_wr = rw;
            check_val("ld_data", s3_data, m_data);
            check_val("ld_r0",   32'(s3_R0_en), 0);
         end else begin
            m_dk = 1'b0; exp_wr = 1'b0;
         end
         check_val("ack_wr",    32'(s3_reg_wr), 32'(exp_wr));
         check_val("ack_instr", 32'(s3_instruction), 32'(ins));
         check_val("ack_req",   32'(dmem_req), 0);
         check_val("ack_busy",  32'(mem_busy), 0);
      end
      check_val("fault", 32'(mem_fault), 32'(m_fault));
   endtask

   initial begin
      rst = 1'b1; halt_sys = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
      in_memc = '0; in_alu_result = '0; in_R1_data = '0;
      in_reg_wr = 1'b0; in_R0_en = 1'b0; in_instr = '0;
      #2;
      check_all_zero("rst");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Directed cases from the block's usage notes.
      run_txn(2'b00, 32'h0003_0042, 16'h0, 1'b1, 1'b1, 8'hA1, 0, 0, 16'h0, 1'b0);
      run_txn(2'b01, 32'h0000_0010, 16'h0, 1'b1, 1'b1, 8'hB2, 0, 2, 16'hBEEF, 1'b0);
      run_txn(2'b10, 32'h0000_0020, 16'h1234, 1'b0, 1'b0, 8'hC3, 0, 0, 16'h0, 1'b0);
      run_txn(2'b01, 32'h0000_0030, 16'h0, 1'b1, 1'b0, 8'hD4, 1, 3, 16'h5A5A, 1'b1);
      run_txn(2'b11, 32'hFFFF_0001, 16'h0, 1'b1, 1'b0, 8'hE5, 3, 0, 16'h0, 1'b0);

      // Reset in the middle of an outstanding load.
      halt_sys = 1'b0; in_memc = 2'b01; in_alu_result = 32'h0000_0040; in_instr = 8'h77; in_reg_wr = 1'b1;
      tick();
      check_val("pre_rst_busy", 32'(mem_busy), 1);
      #2 rst = 1'b1;
      #1 check_all_zero("midrst");
      @(negedge clk);
      rst = 1'b0; halt_sys = 1'b1; dmem_ack = 1'b1; dmem_rdata = 16'hDEAD;
      tick();
      dmem_ack = 1'b0;
      check_val("stray_busy", 32'(mem_busy), 0);
      check_val("stray_req",  32'(dmem_req), 0);
      check_val("stray_wr",   32'(s3_reg_wr), 0);
      check_val("stray_data", s3_data, 0);
      m_data = '0; m_dk = 1'b1; m_instr = '0;

      for (int t = 0; t < 60; t++) begin
         run_txn(2'($urandom), $urandom, 16'($urandom), 1'($urandom), 1'($urandom), 8'($urandom),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
                 int'($urandom_range(0, 5)), 16'($urandom), 1'($urandom));
      end

`ifdef STAGE_THREE_TIMEOUT_EN
      halt_sys = 1'b0; dmem_ack = 1'b0; in_memc = 2'b01; in_alu_result = 32'h0000_0050;
      in_instr = 8'h99; in_reg_wr = 1'b1;
      tick();
      for (int i = 1; i < TIMEOUT_CYCLES; i++) begin
         halt_sys = 1'b1;
         tick();
         check_val("to_busy", 32'(mem_busy), 1);
      end
      tick();
      m_fault = 1'b1;
      check_val("to_req",   32'(dmem_req), 0);
      check_val("to_busy0", 32'(mem_busy), 0);
      check_val("to_wr",    32'(s3_reg_wr), 0);
      check_val("to_fault", 32'(mem_fault), 1);
      check_val("to_instr", 32'(s3_instruction), 32'(m_instr));
      run_txn(2'b01, 32'h0000_0060, 16'h0, 1'b1, 1'b0, 8'h42, 0, 1, 16'h0F0F, 1'b0);
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      check_val("to_fault_clr", 32'(mem_fault), 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule
